layer_scheduler: RTL

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_scheduler_pkg.sv | 17 +
 rtl/layer_addr_gen.sv | 57 +++++
 rtl/layer_scheduler.sv | 118 +++++++++++
 3 files changed

// File: rtl/layer_scheduler_pkg.sv
// Shared types and widths for the layer scheduler and its address generator.
package layer_scheduler_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEAD   = 3'd1,
    STREAM = 3'd2,
    WAIT   = 3'd3,
    STORE  = 3'd4,
    FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/layer_addr_gen.sv
// Element (i) and neuron (j) counters plus x/w/b read-address generators.
// Addresses are running registers, so no multiplier is needed for j*N_IN.
module layer_addr_gen
  import layer_scheduler_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int X_BASE = 0,
  parameter int W_BASE = 1024,
  parameter int B_BASE = 16384
)(
  input  logic              clock,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic              next_j,
  output logic              last_i,
  output logic              last_j,
  output logic [IDX_W-1:0]  j,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] b_addr
);

  logic [ADDR_W-1:0] i;

  assign last_i = (i == ADDR_W'(N_IN - 1));
  assign last_j = (j == IDX_W'(N_OUT - 1));

  always_ff @(posedge clock) begin
    if (rst || clr) begin
      i      <= '0;
      j      <= '0;
      x_addr <= ADDR_W'(X_BASE);
      w_addr <= ADDR_W'(W_BASE);
      b_addr <= ADDR_W'(B_BASE);
    end else begin
      if (step) begin
        // w keeps running across neurons: the word after the last read of
        // neuron j is the first weight of neuron j+1.
        w_addr <= w_addr + 1'b1;
        if (last_i) begin
          i      <= '0;
          x_addr <= ADDR_W'(X_BASE);
        end else begin
          i      <= i + 1'b1;
          x_addr <= x_addr + 1'b1;
        end
      end
      if (next_j) begin
        j      <= j + 1'b1;
        b_addr <= b_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_scheduler.sv
// Sequences one dense layer: per neuron a head pulse, N_IN reads, wait for
// the neuron result, then a result strobe. Define ARGMAX_EN for class_out.
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int X_BASE = 0,
  parameter int W_BASE = 1024,
  parameter int B_BASE = 16384
)(
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              head,
  output logic              rd_en,
  output logic [ADDR_W-1:0] x_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic              neuron_done,
  input  logic [DATA_W-1:0] neuron_out,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_data
`ifdef ARGMAX_EN
  ,
  output logic [IDX_W-1:0]  class_out
`endif
);

  state_t           state, state_n;
  logic             last_i, last_j;
  logic [IDX_W-1:0] j;

  layer_addr_gen #(
    .N_IN(N_IN), .N_OUT(N_OUT),
    .X_BASE(X_BASE), .W_BASE(W_BASE), .B_BASE(B_BASE)
  ) u_addr (
    .clock  (clock),
    .rst    (rst),
    .clr    (state == IDLE),
    .step   (state == HEAD || state == STREAM),
    .next_j (state == STORE && !last_j),
    .last_i (last_i),
    .last_j (last_j),
    .j      (j),
    .x_addr (x_addr),
    .w_addr (w_addr),
    .b_addr (b_addr)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (start) state_n = HEAD;
      HEAD, STREAM: state_n = last_i ? WAIT : STREAM;
      WAIT:         if (neuron_done) state_n = STORE;
      STORE:        state_n = last_j ? FIN : HEAD;
      FIN:          state_n = IDLE;
      default:      state_n = IDLE;
    endcase
  end

  // Strobes are flops decoded from the next state, so they line up with the
  // state register and cannot glitch.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      head      <= 1'b0;
      rd_en     <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_data  <= '0;
    end else begin
      state     <= state_n;
      busy      <= state_n inside {HEAD, STREAM, WAIT, STORE};
      done      <= (state_n == FIN);
      head      <= (state_n == HEAD);
      rd_en     <= state_n inside {HEAD, STREAM};
      res_valid <= (state_n == STORE);
      if (state == WAIT && neuron_done) begin
        res_idx  <= j;
        res_data <= neuron_out;
      end
    end
  end

`ifdef ARGMAX_EN
  logic signed [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]         max_idx;
  logic                     take;

  // Strict greater-than so a tie keeps the earlier (lower) index.
  assign take = (res_idx == '0) || ($signed(res_data) > max_val);

  always_ff @(posedge clock) begin
    if (rst) begin
      max_val   <= '0;
      max_idx   <= '0;
      class_out <= '0;
    end else if (state == IDLE && start) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (state == STORE) begin
      if (take) begin
        max_val <= $signed(res_data);
        max_idx <= res_idx;
      end
      if (last_j) class_out <= take ? res_idx : max_idx;
    end
  end
`endif

endmodule
